// File: rtl/rvh_pmp_chk_queue.sv
// PMP check request queue: in-order FIFO feeding the PMP entry array,
// with a single registered response carrying the access-fault cause.
module rvh_pmp_chk_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PADDR_WIDTH = 56,
    parameter int unsigned TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_vld_i,
    output logic                   req_rdy_o,
    input  logic [PADDR_WIDTH-1:0] req_paddr_i,
    input  logic [1:0]             req_access_type_i,
    input  logic [1:0]             req_priv_lvl_i,
    input  logic [TAG_WIDTH-1:0]   req_tag_i,
    output logic                   pmp_chk_vld_o,
    output logic [PADDR_WIDTH-1:0] pmp_chk_paddr_o,
    output logic [1:0]             pmp_chk_access_type_o,
    output logic [1:0]             pmp_priv_lvl_o,
    input  logic                   pmp_chk_fail_i,
    input  logic                   csr_update_i,
    input  logic                   flush_i,
    output logic                   resp_vld_o,
    input  logic                   resp_rdy_i,
    output logic [TAG_WIDTH-1:0]   resp_tag_o,
    output logic [PADDR_WIDTH-1:0] resp_paddr_o,
    output logic                   resp_fault_o,
    output logic [4:0]             resp_excp_cause_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]   tag;
        logic [1:0]             prv;
        logic [1:0]             acc;
        logic [PADDR_WIDTH-1:0] paddr;
    } ent_t;

    ent_t          mem [DEPTH];
    ent_t          hd;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          enq;
    logic          issue;
    logic          fault_d;
    logic [4:0]    cause_sel;
    logic [4:0]    resp_cause_q;

    assign hd = mem[head];

    assign req_rdy_o = (cnt != CW'(DEPTH)) & !flush_i;
    assign enq       = req_vld_i & req_rdy_o;
    assign issue     = (cnt != '0) & !csr_update_i & !flush_i
                     & (!resp_vld_o | resp_rdy_i);

    assign pmp_chk_vld_o         = issue;
    assign pmp_chk_paddr_o       = hd.paddr;
    assign pmp_chk_access_type_o = hd.acc;
    assign pmp_priv_lvl_o        = hd.prv;

    // Reserved access type is an unconditional fault; the rest of the
    // fail path goes straight into the response flop.
    assign fault_d = pmp_chk_fail_i | (hd.acc == 2'b11);

    always_comb begin
        cause_sel = 5'd5;
        unique case (hd.acc)
            2'b00:   cause_sel = 5'd5;
            2'b01:   cause_sel = 5'd7;
            2'b10:   cause_sel = 5'd1;
            default: cause_sel = 5'd5;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{tag:   req_tag_i,
                           prv:   req_priv_lvl_i,
                           acc:   req_access_type_i,
                           paddr: req_paddr_i};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq)   tail <= tail + PW'(1);
            if (issue) head <= head + PW'(1);
            if (enq && !issue)      cnt <= cnt + CW'(1);
            else if (!enq && issue) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_vld_o   <= 1'b0;
            resp_tag_o   <= '0;
            resp_paddr_o <= '0;
            resp_fault_o <= 1'b0;
            resp_cause_q <= '0;
        end else if (flush_i) begin
            resp_vld_o <= 1'b0;
        end else if (issue) begin
            resp_vld_o   <= 1'b1;
            resp_tag_o   <= hd.tag;
            resp_paddr_o <= hd.paddr;
            resp_fault_o <= fault_d;
            resp_cause_q <= cause_sel;
        end else if (resp_rdy_i) begin
            resp_vld_o <= 1'b0;
        end
    end

    assign resp_excp_cause_o = resp_fault_o ? resp_cause_q : 5'd0;

endmodule

// File: tb/tb_rvh_pmp_chk_queue.sv
// Directed bench for rvh_pmp_chk_queue.
// Expected values are hand-derived from the queue behaviour.
module tb_rvh_pmp_chk_queue;

    logic        clk;
    logic        rstn;
    logic        req_vld_i;
    logic        req_rdy_o;
    logic [55:0] req_paddr_i;
    logic [1:0]  req_access_type_i;
    logic [1:0]  req_priv_lvl_i;
    logic [3:0]  req_tag_i;
    logic        pmp_chk_vld_o;
    logic [55:0] pmp_chk_paddr_o;
    logic [1:0]  pmp_chk_access_type_o;
    logic [1:0]  pmp_priv_lvl_o;
    logic        pmp_chk_fail_i;
    logic        csr_update_i;
    logic        flush_i;
    logic        resp_vld_o;
    logic        resp_rdy_i;
    logic [3:0]  resp_tag_o;
    logic [55:0] resp_paddr_o;
    logic        resp_fault_o;
    logic [4:0]  resp_excp_cause_o;

    int total = 0;
    int bad   = 0;

    rvh_pmp_chk_queue #(
        .DEPTH(4),
        .PADDR_WIDTH(56),
        .TAG_WIDTH(4)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .req_vld_i             (req_vld_i),
        .req_rdy_o             (req_rdy_o),
        .req_paddr_i           (req_paddr_i),
        .req_access_type_i     (req_access_type_i),
        .req_priv_lvl_i        (req_priv_lvl_i),
        .req_tag_i             (req_tag_i),
        .pmp_chk_vld_o         (pmp_chk_vld_o),
        .pmp_chk_paddr_o       (pmp_chk_paddr_o),
        .pmp_chk_access_type_o (pmp_chk_access_type_o),
        .pmp_priv_lvl_o        (pmp_priv_lvl_o),
        .pmp_chk_fail_i        (pmp_chk_fail_i),
        .csr_update_i          (csr_update_i),
        .flush_i               (flush_i),
        .resp_vld_o            (resp_vld_o),
        .resp_rdy_i            (resp_rdy_i),
        .resp_tag_o            (resp_tag_o),
        .resp_paddr_o          (resp_paddr_o),
        .resp_fault_o          (resp_fault_o),
        .resp_excp_cause_o     (resp_excp_cause_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] pa(input int k);
        return 56'h8000_0000 + 56'(k) * 56'h1000;
    endfunction

    task automatic drv(input logic v, input logic [1:0] acc,
                       input int k, input logic [55:0] a);
        req_vld_i         = v;
        req_access_type_i = acc;
        req_tag_i         = 4'(k);
        req_paddr_i       = a;
    endtask

    logic [1:0] t2_ty [3];
    logic [4:0] t2_cs [3];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        t2_ty = '{2'b10, 2'b00, 2'b01};
        t2_cs = '{5'd1, 5'd5, 5'd7};
        clk = 0;
        rstn = 0;
        drv(0, 2'b00, 0, '0);
        req_priv_lvl_i = 2'd3;
        pmp_chk_fail_i = 0;
        csr_update_i   = 0;
        flush_i        = 0;
        resp_rdy_i     = 0;
        #12;
        chk("rst_rdy", req_rdy_o, 1);
        chk("rst_chk", pmp_chk_vld_o, 0);
        chk("rst_vld", resp_vld_o, 0);
        chk("rst_flt", resp_fault_o, 0);
        chk("rst_cause", resp_excp_cause_o, 0);
        chk("rst_tag", resp_tag_o, 0);
        chk("rst_pa", resp_paddr_o, 0);
        rstn = 1;
        tick();

        // single load, pass
        resp_rdy_i = 1;
        drv(1, 2'b00, 3, 56'h8000_0000);
        #1;
        chk("t1_rdy", req_rdy_o, 1);
        chk("t1_chk_n", pmp_chk_vld_o, 0);
        tick();
        drv(0, 2'b00, 0, '0);
        #1;
        chk("t1_chk", pmp_chk_vld_o, 1);
        chk("t1_chk_pa", pmp_chk_paddr_o, 56'h8000_0000);
        chk("t1_chk_ty", pmp_chk_access_type_o, 0);
        chk("t1_chk_pl", pmp_priv_lvl_o, 3);
        chk("t1_vld_n", resp_vld_o, 0);
        tick();
        chk("t1_vld", resp_vld_o, 1);
        chk("t1_tag", resp_tag_o, 3);
        chk("t1_pa", resp_paddr_o, 56'h8000_0000);
        chk("t1_flt", resp_fault_o, 0);
        chk("t1_cause", resp_excp_cause_o, 0);
        chk("t1_chk_idle", pmp_chk_vld_o, 0);
        tick();
        chk("t1_done", resp_vld_o, 0);

        // fetch, load, store all failing
        pmp_chk_fail_i = 1;
        for (int s = 0; s < 5; s++) begin
            if (s < 3) drv(1, t2_ty[s], s + 1, pa(s + 1));
            else drv(0, 2'b00, 0, '0);
            tick();
            if (s >= 1 && s <= 3) begin
                chk("t2_vld", resp_vld_o, 1);
                chk("t2_tag", resp_tag_o, 64'(s));
                chk("t2_flt", resp_fault_o, 1);
                chk("t2_cause", resp_excp_cause_o, t2_cs[s-1]);
            end
            if (s == 4) chk("t2_done", resp_vld_o, 0);
        end
        pmp_chk_fail_i = 0;

        // backpressure fills queue
        resp_rdy_i = 0;
        for (int k = 0; k < 6; k++) begin
            drv(1, 2'b00, k, pa(k));
            #1;
            chk("t3_rdy", req_rdy_o, (k < 5) ? 1 : 0);
            tick();
        end
        drv(0, 2'b00, 0, '0);
        resp_rdy_i = 1;
        for (int j = 0; j < 5; j++) begin
            chk("t3_vld", resp_vld_o, 1);
            chk("t3_tag", resp_tag_o, 64'(j));
            chk("t3_pa", resp_paddr_o, pa(j));
            tick();
        end
        chk("t3_done", resp_vld_o, 0);

        // csr update stalls issue
        csr_update_i = 1;
        drv(1, 2'b00, 6, pa(6));
        #1;
        chk("t4_enq", req_rdy_o, 1);
        tick();
        drv(1, 2'b00, 7, pa(7));
        tick();
        drv(0, 2'b00, 0, '0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_stall", pmp_chk_vld_o, 0);
            chk("t4_novld", resp_vld_o, 0);
            tick();
        end
        csr_update_i = 0;
        #1;
        chk("t4_go", pmp_chk_vld_o, 1);
        chk("t4_go_pa", pmp_chk_paddr_o, pa(6));
        tick();
        chk("t4_r0", resp_tag_o, 6);
        tick();
        chk("t4_r1", resp_tag_o, 7);
        chk("t4_r1v", resp_vld_o, 1);
        tick();
        chk("t4_done", resp_vld_o, 0);

        // flush with 3 queued and a stalled response
        resp_rdy_i = 0;
        for (int k = 8; k < 12; k++) begin
            drv(1, 2'b00, k, pa(k));
            tick();
        end
        drv(0, 2'b00, 0, '0);
        chk("t5_pre_vld", resp_vld_o, 1);
        chk("t5_pre_tag", resp_tag_o, 8);
        flush_i = 1;
        drv(1, 2'b00, 12, pa(12));
        #1;
        chk("t5_rdy", req_rdy_o, 0);
        chk("t5_chk", pmp_chk_vld_o, 0);
        tick();
        flush_i = 0;
        drv(0, 2'b00, 0, '0);
        #1;
        chk("t5_vld", resp_vld_o, 0);
        chk("t5_empty", pmp_chk_vld_o, 0);
        chk("t5_rdy_back", req_rdy_o, 1);
        resp_rdy_i = 1;
        tick();
        tick();
        chk("t5_none", resp_vld_o, 0);

        // reserved access type always faults
        drv(1, 2'b11, 13, pa(13));
        tick();
        drv(0, 2'b00, 0, '0);
        tick();
        chk("t6_vld", resp_vld_o, 1);
        chk("t6_tag", resp_tag_o, 13);
        chk("t6_flt", resp_fault_o, 1);
        chk("t6_cause", resp_excp_cause_o, 5);
        tick();

        // async reset mid-stream
        pmp_chk_fail_i = 1;
        resp_rdy_i = 0;
        drv(1, 2'b01, 14, pa(14));
        tick();
        drv(1, 2'b01, 15, pa(15));
        tick();
        drv(0, 2'b00, 0, '0);
        resp_rdy_i = 1;
        #1;
        chk("t7_pre_vld", resp_vld_o, 1);
        chk("t7_pre_flt", resp_fault_o, 1);
        chk("t7_pre_chk", pmp_chk_vld_o, 1);
        rstn = 0;
        #1;
        chk("t7_vld", resp_vld_o, 0);
        chk("t7_flt", resp_fault_o, 0);
        chk("t7_cause", resp_excp_cause_o, 0);
        chk("t7_tag", resp_tag_o, 0);
        chk("t7_pa", resp_paddr_o, 0);
        chk("t7_chk", pmp_chk_vld_o, 0);
        chk("t7_rdy", req_rdy_o, 1);
        #2;
        rstn = 1;
        pmp_chk_fail_i = 0;
        tick();
        chk("t7_lost", resp_vld_o, 0);
        chk("t7_lost_chk", pmp_chk_vld_o, 0);
        tick();
        chk("t7_lost2", resp_vld_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
